// File: rtl/keypad_pkg.sv
// Shared types and constant tables for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESS    = 2'd2,
    HELD     = 2'd3
  } scan_state_t;

  // Row-major key codes; the row 3 order matches the Pmod KYPD silkscreen.
  localparam logic [3:0] KEY_MAP [0:3][0:3] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  localparam logic [3:0] COL_DRIVE [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous bits.
// Flops reset to all-ones, which is the idle level of the keypad rows.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, press/release debounce, hex key code
// and a digit shift array shaped like the display driver's data_in.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int COL_BITS        = 4,
  parameter int ROW_BITS        = 4,
  parameter int KEY_BITS        = 4,
  parameter int DIGIT_COUNT     = 4,
  parameter int SETTLE_CYCLES   = 1000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ROW_BITS-1:0] row_in,
  output logic [COL_BITS-1:0] col_out,
  output logic [KEY_BITS-1:0] key_code,
  output logic                key_valid,
  output logic                key_held,
  output logic [KEY_BITS-1:0] digits_out [DIGIT_COUNT]
);

  localparam int CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int CIW     = $clog2(COL_BITS);
  localparam int RIW     = $clog2(ROW_BITS);
  localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0]  DEB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CIW-1:0] COL_LAST    = CIW'(COL_BITS - 1);

  scan_state_t         state;
  logic [CW-1:0]       cnt;
  logic [CIW-1:0]      col_idx;
  logic [CIW-1:0]      col_next;
  logic [ROW_BITS-1:0] row_sync;
  logic [ROW_BITS-1:0] pat;
  logic [RIW-1:0]      row_idx;
  logic                idle;

  sync_2ff #(.WIDTH(ROW_BITS)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_in),
    .q   (row_sync)
  );

  assign idle     = &row_sync;
  assign col_next = (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;
  assign col_out  = COL_BITS'(COL_DRIVE[col_idx]);

  // Lowest-index pressed row wins when several rows are low.
  always_comb begin
    row_idx = '0;
    for (int r = ROW_BITS - 1; r >= 0; r--)
      if (!pat[r]) row_idx = RIW'(r);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      cnt       <= '0;
      col_idx   <= '0;
      pat       <= '1;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      for (int i = 0; i < DIGIT_COUNT; i++) digits_out[i] <= '0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (cnt != SETTLE_LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (idle) begin
              col_idx <= col_next;
            end else begin
              pat   <= row_sync;
              state <= DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (row_sync != pat) begin
            cnt   <= '0;
            state <= SCAN;
          end else if (cnt == DEB_LAST) begin
            // Outputs are registered on entry so they are visible during PRESS.
            cnt       <= '0;
            state     <= PRESS;
            key_valid <= 1'b1;
            key_code  <= KEY_BITS'(KEY_MAP[row_idx][col_idx]);
            digits_out[0] <= KEY_BITS'(KEY_MAP[row_idx][col_idx]);
            for (int i = DIGIT_COUNT - 1; i > 0; i--) digits_out[i] <= digits_out[i-1];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESS: begin
          key_held <= 1'b1;
          cnt      <= '0;
          state    <= HELD;
        end
        HELD: begin
          if (!idle) begin
            cnt <= '0;
          end else if (cnt == DEB_LAST) begin
            cnt      <= '0;
            key_held <= 1'b0;
            col_idx  <= col_next;
            state    <= SCAN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench: a behavioural keypad matrix drives row_in from col_out.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [3:0] digits [4];

  logic [3:0][3:0] pm = '0;  // pm[row][col] = key physically down
  int n_vec = 0;
  int n_bad = 0;
  int vld_cnt = 0;

  always #5 clk = ~clk;

  always_comb
    for (int r = 0; r < 4; r++) row_in[r] = ~|(pm[r] & ~col_out);

  always @(negedge clk) if (key_valid) vld_cnt++;

  keypad_scanner #(
    .SETTLE_CYCLES   (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row_in     (row_in),
    .col_out    (col_out),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_held   (key_held),
    .digits_out (digits)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic wait_col_change(input logic [3:0] exp);
    logic [3:0] prev = col_out;
    int n = 0;
    while (col_out == prev && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("col_seq", col_out, exp);
  endtask

  task automatic wait_valid(input string tag, input logic [3:0] code);
    int n = 0;
    while (!key_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_seen"}, key_valid, 1'b1);
    chk({tag, "_code"}, key_code, code);
  endtask

  task automatic wait_release(input string tag, output int n);
    n = 0;
    while (key_held && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_held_drop"}, key_held, 1'b0);
  endtask

  task automatic press_release(input int r, input int c, input logic [3:0] code);
    int n;
    int v0 = vld_cnt;
    pm[r][c] = 1'b1;
    wait_valid("seq", code);
    repeat (3) @(negedge clk);
    pm[r][c] = 1'b0;
    wait_release("seq", n);
    chk("seq_one_pulse", vld_cnt - v0, 1);
  endtask

  initial begin
    int n;
    int v0;

    // 1: reset state and idle column rotation
    repeat (3) @(negedge clk);
    chk("rst_col", col_out, 4'b1110);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_held", key_held, 1'b0);
    chk("rst_digits", {digits[3], digits[2], digits[1], digits[0]}, 16'h0000);
    rst = 1'b0;
    wait_col_change(4'b1101);
    wait_col_change(4'b1011);
    wait_col_change(4'b0111);
    wait_col_change(4'b1110);

    // 2: key 6 (row1, col2), held then released
    v0 = vld_cnt;
    pm[1][2] = 1'b1;
    wait_valid("k6", 4'h6);
    chk("k6_digit0", digits[0], 4'h6);
    repeat (20) @(negedge clk);
    chk("k6_held", key_held, 1'b1);
    chk("k6_col_kept", col_out, 4'b1011);
    chk("k6_no_repeat", vld_cnt - v0, 1);
    pm[1][2] = 1'b0;
    wait_release("k6", n);
    chk("k6_release_lat", (n >= 8 && n <= 12), 1'b1);

    // 3: bouncing key 1, then stable
    v0 = vld_cnt;
    for (int i = 0; i < 10; i++) begin
      pm[0][0] = ~pm[0][0];
      repeat (3) @(negedge clk);
    end
    chk("bounce_quiet", vld_cnt - v0, 0);
    pm[0][0] = 1'b1;
    wait_valid("bounce", 4'h1);
    repeat (3) @(negedge clk);
    chk("bounce_one", vld_cnt - v0, 1);
    pm[0][0] = 1'b0;
    wait_release("bounce", n);

    // 4: keys 1..5 in turn fill the digit array
    press_release(0, 0, 4'h1);
    press_release(0, 1, 4'h2);
    press_release(0, 2, 4'h3);
    press_release(1, 0, 4'h4);
    press_release(1, 1, 4'h5);
    chk("digits_12345", {digits[0], digits[1], digits[2], digits[3]}, 16'h5432);

    // 5: rows 0 and 3 on column 0 -> lowest row wins
    pm[0][0] = 1'b1;
    pm[3][0] = 1'b1;
    wait_valid("multi", 4'h1);
    repeat (2) @(negedge clk);
    pm[0][0] = 1'b0;
    pm[3][0] = 1'b0;
    wait_release("multi", n);
    // key A pressed while 6 is held is ignored
    pm[1][2] = 1'b1;
    wait_valid("hold6", 4'h6);
    repeat (2) @(negedge clk);
    v0 = vld_cnt;
    pm[0][3] = 1'b1;
    repeat (60) @(negedge clk);
    chk("hold6_ignore_a", vld_cnt - v0, 0);
    chk("hold6_code", key_code, 4'h6);
    pm[0][3] = 1'b0;
    pm[1][2] = 1'b0;
    wait_release("hold6", n);

    // 6: reset during HELD, then key D
    pm[0][1] = 1'b1;
    wait_valid("pre_rst", 4'h2);
    repeat (3) @(negedge clk);
    chk("pre_rst_held", key_held, 1'b1);
    rst = 1'b1;
    pm[0][1] = 1'b0;
    @(negedge clk);
    chk("mid_rst_held", key_held, 1'b0);
    chk("mid_rst_col", col_out, 4'b1110);
    chk("mid_rst_valid", key_valid, 1'b0);
    chk("mid_rst_digit0", digits[0], 4'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    v0 = vld_cnt;
    pm[3][3] = 1'b1;
    wait_valid("kd", 4'hD);
    repeat (20) @(negedge clk);
    chk("kd_one", vld_cnt - v0, 1);
    chk("kd_digit0", digits[0], 4'hD);
    pm[3][3] = 1'b0;
    wait_release("kd", n);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4x4 active-low matrix keypad (Pmod KYPD layout), debounces presses, and converts each press into a 4-bit hex key code. It is the input-side counterpart of the seven-segment display driver. Each accepted key shifts into a DIGIT_COUNT-deep digit array whose shape and bit ordering match the display driver's data_in, so the two blocks connect directly.

Parameters:
COL_BITS, 4, number of keypad columns (active-low drive)
ROW_BITS, 4, number of keypad rows (active-low sense)
KEY_BITS, 4, width of key code and each digit
DIGIT_COUNT, 4, depth of the digit shift array
SETTLE_CYCLES, 1000, cycles to wait after a column change before sampling rows
DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a press or a release (5 ms at 100 MHz)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
row_in  input  ROW_BITS  raw keypad rows, asynchronous, active-low
col_out  output  COL_BITS  column drive, one-hot active-low
key_code  output  KEY_BITS  code of the last accepted key
key_valid  output  1  one-cycle pulse when a key is accepted
key_held  output  1  high while an accepted key is still down
digits_out  output  KEY_BITS x DIGIT_COUNT  unpacked array; index 0 holds the newest key

Behaviour:
- Reset values: col_out=4'b1110 (column 0), key_code=0, key_valid=0, key_held=0, all digits_out=0, FSM=SCAN, counters=0, synchronizer flops=all-ones.
- row_in passes through a 2-flop synchronizer (row_sync). A row is pressed when its row_sync bit is 0.
- SCAN:
  - Drive column c. Count SETTLE_CYCLES cycles, then sample row_sync.
  - If row_sync is all ones, advance c (wrap from 3 to 0), update col_out, restart the settle count.
  - Otherwise capture the row pattern and go to DEBOUNCE. Keep the column.
- DEBOUNCE:
  - Each cycle, compare row_sync with the captured pattern.
  - On a mismatch, return to SCAN on the same column and restart the settle count.
  - After DEBOUNCE_CYCLES consecutive matches, go to PRESS.
- PRESS (exactly one cycle):
  - key_valid=1.
  - key_code = KEY_MAP[r][c], where r is the lowest-index pressed row in the captured pattern (multiple rows pressed: lowest row wins).
  - Shift the digit array: digits_out[0] <= code; digits_out[i] <= digits_out[i-1]; the oldest digit is dropped.
  - Next state is HELD.
- HELD:
  - key_held=1. Keep the column.
  - Count consecutive cycles with row_sync all ones; any zero resets the count.
  - After DEBOUNCE_CYCLES consecutive all-ones cycles: key_held=0, advance the column, go to SCAN.
  - Other keys pressed while in HELD are ignored and never produce key_valid.
- key_code and digits_out change only in PRESS and otherwise hold their values.
- Latency: key_valid rises SETTLE_CYCLES + DEBOUNCE_CYCLES + 3 (±1) cycles after a clean press whose column is already driven.
- Holding a key never repeats: exactly one key_valid per press/release cycle.
- Reset asserted mid-operation (any state) forces the reset values on the next edge. No key_valid is emitted in that cycle.
- Counter widths: $clog2(max(SETTLE_CYCLES, DEBOUNCE_CYCLES)+1). Counters never wrap.

Decomposition:
- Package keypad_pkg:
  - scan_state_t enum: SCAN, DEBOUNCE, PRESS, HELD.
  - KEY_MAP[ROW][COL] localparam:
    - row0: 1 2 3 A
    - row1: 4 5 6 B
    - row2: 7 8 9 C
    - row3: 0 F E D
  - COL_DRIVE[4] one-hot active-low column patterns.
- One sub-module, sync_2ff (parameterised width, reset-to-ones), for the row synchronizer. The FSM, counters and digit shift stay in keypad_scanner.

Test Plan:
All scenarios use SETTLE_CYCLES=4 and DEBOUNCE_CYCLES=8.
1. Assert rst 3 cycles -> col_out=4'b1110, key_valid=0, key_held=0, digits_out all 0. Idle with no key -> col_out cycles 1110, 1101, 1011, 0111, 1110.
2. Hold row1 low while column 2 is driven -> exactly one key_valid, key_code=4'h6, digits_out[0]=6, key_held=1 until 8 cycles after release.
3. Toggle row0 every 3 cycles for 30 cycles during column 0, then hold stable -> exactly one key_valid with key_code=1, none during the bounce.
4. Press and release keys 1, 2, 3, 4, 5 in turn -> five key_valid pulses, digits_out[0..3]={5,4,3,2}.
5. Rows 0 and 3 low on column 0 -> key_code=1. With key 6 held, also press key A -> no second key_valid.
6. Assert rst during HELD -> next cycle key_held=0, col_out=1110, no key_valid. Release, then press key D -> a single key_valid with key_code=4'hD.
